// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer/compare peripheral:
// register offsets, CTRL bit positions, reset constants and byte-lane merge.
package timer_pkg;

    typedef enum logic [1:0] {
        TIMER_CTRL     = 2'd0,
        TIMER_PRESCALE = 2'd1,
        TIMER_COUNT    = 2'd2,
        TIMER_COMPARE  = 2'd3
    } timer_reg_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_AUTO = 2;
    localparam int CTRL_PEND = 8;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..reload and emits a one-cycle tick on reaching reload.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    input  logic                      load_clr,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pc_reg;

    // Tick follows the registered enable, so an EN-clear write still ticks in its own cycle.
    assign tick = en && (pc_reg == reload);

    always_ff @(posedge clk) begin
        if (rst || load_clr || !en || tick) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_reg + 1'b1;
        end
    end

endmodule

// File: rtl/timer.sv
// 32-bit timer/compare peripheral on the picorv32 native bus: register file,
// single-cycle acknowledge handshake, compare match with sticky PEND and level IRQ.
module timer
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        irq
);

    logic        ready_reg;
    logic        irq_reg;
    logic [31:0] dout_reg;

    logic        en_reg;
    logic        ie_reg;
    logic        auto_reg;
    logic        pend_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;

    timer_reg_e  reg_sel;
    logic        wr_commit;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        pend_clr;
    logic        tick;
    logic        match;
    logic [31:0] ctrl_rd;
    logic [31:0] prescale_ext;
    logic [31:0] rd_data;
    logic [PRESCALE_WIDTH-1:0] prescale_next;

    assign reg_sel = timer_reg_e'(addr);

    // A write lands on the edge that ends the ready cycle, exactly once per transfer.
    assign wr_commit   = cs && ready_reg && (we != 4'b0000);
    assign wr_ctrl     = wr_commit && (reg_sel == TIMER_CTRL);
    assign wr_prescale = wr_commit && (reg_sel == TIMER_PRESCALE);
    assign wr_count    = wr_commit && (reg_sel == TIMER_COUNT);
    assign wr_compare  = wr_commit && (reg_sel == TIMER_COMPARE);
    assign pend_clr    = wr_ctrl && we[1] && din[CTRL_PEND];

    assign match        = (count_reg == compare_reg);
    assign prescale_ext = 32'(prescale_reg);

    genvar gi;
    generate
        for (gi = 0; gi < PRESCALE_WIDTH; gi++) begin : g_prescale_bit
            assign prescale_next[gi] = we[gi / 8] ? din[gi] : prescale_reg[gi];
        end
    endgenerate

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en_reg),
        .reload   (prescale_reg),
        .load_clr (wr_prescale),
        .tick     (tick)
    );

    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[CTRL_EN]   = en_reg;
        ctrl_rd[CTRL_IE]   = ie_reg;
        ctrl_rd[CTRL_AUTO] = auto_reg;
        ctrl_rd[CTRL_PEND] = pend_reg;
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            TIMER_CTRL:     rd_data = ctrl_rd;
            TIMER_PRESCALE: rd_data = prescale_ext;
            TIMER_COUNT:    rd_data = count_reg;
            TIMER_COMPARE:  rd_data = compare_reg;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg    <= 1'b0;
            dout_reg     <= '0;
            irq_reg      <= 1'b0;
            en_reg       <= 1'b0;
            ie_reg       <= 1'b0;
            auto_reg     <= 1'b0;
            pend_reg     <= 1'b0;
            prescale_reg <= '0;
            count_reg    <= '0;
            compare_reg  <= COMPARE_RESET;
        end else begin
            ready_reg <= cs && !ready_reg;
            // Capture read data when cs is first seen; outside the ready cycle dout is 0.
            dout_reg  <= (cs && !ready_reg) ? rd_data : '0;
            irq_reg   <= pend_reg && ie_reg;

            if (wr_ctrl && we[0]) begin
                en_reg   <= din[CTRL_EN];
                ie_reg   <= din[CTRL_IE];
                auto_reg <= din[CTRL_AUTO];
            end

            // A match on this tick wins over a simultaneous clear.
            if (tick && match) begin
                pend_reg <= 1'b1;
            end else if (pend_clr) begin
                pend_reg <= 1'b0;
            end

            if (wr_prescale) begin
                prescale_reg <= prescale_next;
            end

            if (wr_count) begin
                count_reg <= byte_merge(count_reg, din, we);
            end else if (tick) begin
                count_reg <= (match && auto_reg) ? 32'd0 : count_reg + 32'd1;
            end

            if (wr_compare) begin
                compare_reg <= byte_merge(compare_reg, din, we);
            end
        end
    end

    assign ready = ready_reg;
    assign dout  = dout_reg;
    assign irq   = irq_reg;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for the timer: directed scenarios plus random bus traffic,
// checked against a tick-schedule reference model of the register behaviour.
module tb_timer;

    localparam int          PW      = 16;
    localparam logic [31:0] PS_MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs  = 1'b0;
    logic [3:0]  we  = 4'b0000;
    logic [1:0]  addr = 2'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        ready;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    timer #(.PRESCALE_WIDTH(PW)) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .ready (ready),
        .irq   (irq)
    );

    always #20 clk = ~clk;

    // Reference model state
    logic        m_en, m_ie, m_auto, m_pend, m_irq, m_ready;
    logic [31:0] m_ps, m_count, m_compare;
    longint      cyc = 0;
    longint      phase0 = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  addr_q[$];

    function automatic logic [31:0] apply_strobes(input logic [31:0] old_v,
                                                  input logic [31:0] new_v,
                                                  input logic [3:0]  s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: begin v[0] = m_en; v[1] = m_ie; v[2] = m_auto; v[8] = m_pend; end
            2'd1: v = m_ps;
            2'd2: v = m_count;
            default: v = m_compare;
        endcase
        return v;
    endfunction

    // Model: ticks fall every (PRESCALE+1) cycles counted from the last prescaler restart.
    initial begin
        bit          tk, commit, first, pset;
        logic [31:0] nc;
        logic        np;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_en = 0; m_ie = 0; m_auto = 0; m_pend = 0; m_irq = 0; m_ready = 0;
                m_ps = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
                phase0 = cyc + 1;
            end else begin
                tk     = m_en && (((cyc - phase0) % (longint'(m_ps) + 1)) == longint'(m_ps));
                commit = m_ready && cs && (we != 4'b0000);
                first  = cs && !m_ready;
                if (first) begin
                    exp_q.push_back(reg_value(addr));
                    addr_q.push_back(addr);
                end
                nc = m_count;
                np = m_pend;
                pset = 0;
                if (tk) begin
                    if (m_count == m_compare) begin
                        pset = 1;
                        np = 1;
                        nc = m_auto ? 32'd0 : m_count + 32'd1;
                    end else begin
                        nc = m_count + 32'd1;
                    end
                end
                m_irq = m_pend && m_ie;
                if (!m_en) phase0 = cyc + 1;
                if (commit) begin
                    case (addr)
                        2'd0: begin
                            if (we[0]) begin
                                m_en = din[0]; m_ie = din[1]; m_auto = din[2];
                            end
                            if (we[1] && din[8] && !pset) np = 0;
                        end
                        2'd1: begin
                            m_ps = apply_strobes(m_ps, din, we) & PS_MASK;
                            phase0 = cyc + 1;
                        end
                        2'd2: nc = apply_strobes(m_count, din, we);
                        default: m_compare = apply_strobes(m_compare, din, we);
                    endcase
                end
                m_count = nc;
                m_pend  = np;
                m_ready = cs && !m_ready;
            end
            cyc++;
        end
    end

    // Monitor: pops an expectation for every acknowledge and tracks irq every cycle.
    initial begin
        logic        prev_ready;
        logic [31:0] e;
        logic [1:0]  a;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (irq !== m_irq) begin
                n_err++;
                $display("FAIL irq t=%0t got=%0b want=%0b", $time, irq, m_irq);
            end
            if (ready) begin
                n_cmp++;
                if (prev_ready) begin
                    n_err++;
                    $display("FAIL double_ack t=%0t ready high two cycles", $time);
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ready t=%0t dout=%08h", $time, dout);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    if (dout !== e) begin
                        n_err++;
                        $display("FAIL dout addr=%0d got=%08h want=%08h", a, dout, e);
                    end else begin
                        $display("xfer addr=%0d dout=%08h ok", a, dout);
                    end
                end
            end else if (prev_ready) begin
                n_cmp++;
                if (dout !== 32'd0) begin
                    n_err++;
                    $display("FAIL dout_idle got=%08h want=00000000", dout);
                end
            end
            prev_ready = ready;
        end
    end

    task automatic bus_xfer(input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] w, input bit rst_mid);
        int waited;
        waited = 0;
        cs = 1'b1; addr = a; din = d; we = w;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!ready && waited < 8);
        n_cmp++;
        if (!ready) begin
            n_err++;
            $display("FAIL handshake_timeout ready=%0b want=1", ready);
        end
        if (rst_mid) begin
            rst = 1'b1;
            @(posedge clk); #1;
            cs = 1'b0; we = 4'b0000;
            n_cmp++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL rst_ready got=%0b want=0", ready);
            end
            n_cmp++;
            if (irq !== 1'b0) begin
                n_err++;
                $display("FAIL rst_irq got=%0b want=0", irq);
            end
            rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            cs = 1'b0; we = 4'b0000;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_xfer(a, d, 4'hF, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        bus_xfer(a, 32'd0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  a;
        logic [3:0]  w;
        logic [31:0] d;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values of all registers
        for (int i = 0; i < 4; i++) rd(2'(i));

        // Prescale 3, compare 5, auto-reload with interrupt
        wr(2'd1, 32'd3);
        wr(2'd3, 32'd5);
        wr(2'd0, 32'h7);
        idle(40);
        rd(2'd2);
        rd(2'd0);

        // Clear PEND, then clear while a match lands every tick
        wr(2'd0, 32'h107);
        rd(2'd0);
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd0);
        idle(3);
        wr(2'd0, 32'h107);
        rd(2'd0);

        // Reset in the middle of a COMPARE write while irq is high
        bus_xfer(2'd3, 32'h1234_5678, 4'hF, 1'b1);
        rd(2'd3);

        // Wrap through 0xFFFFFFFF without auto-reload
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd3);
        wr(2'd2, 32'hFFFF_FFFE);
        wr(2'd0, 32'h3);
        for (int i = 0; i < 4; i++) rd(2'd2);
        rd(2'd0);

        // Byte-lane write and COUNT write during a tick
        wr(2'd0, 32'h100);
        wr(2'd3, 32'd0);
        bus_xfer(2'd3, 32'h0000_AB00, 4'b0010, 1'b0);
        rd(2'd3);
        wr(2'd0, 32'h1);
        wr(2'd2, 32'h0000_1000);
        rd(2'd2);
        wr(2'd0, 32'h0);
        rd(2'd2);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            case (a)
                2'd0:    d = $urandom & 32'h0000_0107;
                2'd1:    d = $urandom_range(0, 5);
                2'd2:    d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                         : $urandom_range(0, 20);
                default: d = $urandom_range(0, 20);
            endcase
            bus_xfer(a, d, w, 1'b0);
            idle($urandom_range(0, 5));
        end

        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations got=%0d want=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Memory-mapped 32-bit timer/compare peripheral on the picorv32 native memory bus, decoded by the top-level chip select like the LED, UART and encoder blocks. A programmable prescaler divides the system clock into ticks, a 32-bit counter advances on each tick, and a compare match sets a sticky pending flag that drives one bit of the CPU IRQ vector. The block supplies the system tick for firmware delays and scheduling.

## Interface

Parameters:
- `PRESCALE_WIDTH`, 16: width of the prescaler reload register and counter.

Ports:
- `clk` in 1: system clock (25 MHz).
- `rst` in 1: synchronous, active-high reset.
- `cs` in 1: chip select, which is `cpu_mem_valid` and the address decode; held until `ready`.
- `we` in 4: byte write strobes (`cpu_mem_wstrb`); all zero means a read.
- `addr` in 2: word address within the block (`cpu_mem_addr[3:2]`).
- `din` in 32: write data.
- `dout` out 32: read data, valid while `ready` is high.
- `ready` out 1: transfer acknowledge.
- `irq` out 1: interrupt request, level.

Decided: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation

- Register map, word offsets:
  - 0x0 CTRL: bit0 EN, bit1 IE, bit2 AUTO, bit8 PEND. PEND is read-only set; writing 1 to bit8 clears it.
  - 0x4 PRESCALE: the low `PRESCALE_WIDTH` bits are valid; upper bits read 0.
  - 0x8 COUNT.
  - 0xC COMPARE.
- Byte strobes apply per byte to every register. The write-1-to-clear on PEND uses strobe `we[1]`.
- Prescaler, when EN=1:
  - The prescale counter `pc` counts 0..PRESCALE.
  - When `pc`==PRESCALE, `tick` is asserted for one cycle and `pc` returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - When EN=0, `pc` holds at 0 and no ticks occur.
- On each tick:
  - If COUNT==COMPARE: PEND is set to 1. COUNT becomes 0 if AUTO=1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1, modulo 2^32: 0xFFFFFFFF wraps to 0 without setting PEND unless COMPARE matches.
- `irq` is a registered copy of PEND & IE.
- Precedence within one cycle:
  - A CPU write to COUNT beats a tick update; the written value lands and that tick's increment is lost.
  - A PEND set beats a CPU clear.
  - A write to PRESCALE resets `pc` to 0.
  - Clearing EN takes effect the next cycle. A tick that occurs in the same cycle as the EN-clear write still updates COUNT.

## Timing

- Bus handshake:
  - `ready` <= `cs` & !`ready`. This gives exactly one `ready` cycle, which arrives 1 cycle after `cs` rises.
  - It never double-acknowledges while `cs` is still high in the cycle after `ready`.
- Writes commit on the clock edge that ends the `ready` cycle, i.e. they are applied once per transfer.
- `dout` is registered from the addressed register in the cycle `cs` is first seen. It shows the pre-write register value, and is 0 when `ready` is low.
- Reset values:
  - CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = 0xFFFFFFFF, `pc` = 0.
  - Outputs: `ready` = 0, `dout` = 0, `irq` = 0.
- A reset asserted mid-transfer drops `ready` the following cycle and discards the pending write.
- `irq` latency:
  - The tick edge sets PEND at cycle N.
  - `irq` is high at N+1.
  - After the clearing write commits at cycle M, `irq` is low at M+1.

## Structure

- Shared package `timer_pkg`:
  - Register offsets `TIMER_CTRL`, `TIMER_PRESCALE`, `TIMER_COUNT`, `TIMER_COMPARE`.
  - CTRL bit indices EN, IE, AUTO, PEND.
  - Reset constant for COMPARE.
- One sub-module, `timer_prescaler`:
  - Inputs: `clk`, `rst`, enable, reload value, load-clear.
  - Output: `tick`.
- The top level holds the register file, bus handshake, compare logic and IRQ.
- Top-level integration: chip select at 0x6000, `irq` on `cpu_irq[4]`.

## Test plan

- After reset, read all four registers: expect 0x0, 0x0, 0x0, 0xFFFFFFFF. `ready` pulses exactly one cycle per read, with `cs` held 2 cycles.
- PRESCALE=3, COMPARE=5, CTRL=0x7 (EN|IE|AUTO):
  - Ticks come every 4 cycles.
  - PEND sets on the 6th tick; `irq` rises 1 cycle later.
  - COUNT reads 0 after the match.
- With PEND set, write CTRL=0x107: PEND clears and `irq` falls 1 cycle after the commit. Forcing a match in the same cycle as the clear leaves PEND=1.
- AUTO=0, COUNT=0xFFFFFFFE, COMPARE=3, PRESCALE=0, EN=1: COUNT goes to 0xFFFFFFFF, then 0, 1, 2, 3. PEND sets on the tick where COUNT==3, and COUNT continues to 4.
- Byte write `we`=4'b0010 of 0xAB00 to COMPARE=0: COMPARE becomes 0x0000AB00. Writing COUNT in a tick cycle leaves the written value, not the value plus one.
- Assert `rst` during a write transfer to COMPARE: COMPARE stays 0xFFFFFFFF, and `ready` and `irq` are 0 the next cycle.
